// File: rtl/seven_segment_scanner_if.sv
// Display bus between the score/debug logic (master) and the seven-segment scanner (slave).
interface seven_segment_scanner_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   blank;
  logic                enable;
  logic [6:0]          seg;
  logic                dp;
  logic [DIGITS-1:0]   an;
  logic                frame_tick;

  modport master (
    output value, dp_in, blank, enable,
    input  seg, dp, an, frame_tick
  );

  modport slave (
    input  value, dp_in, blank, enable,
    output seg, dp, an, frame_tick
  );
endinterface

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed seven-segment driver: frame-latched shadows, shared hex decoder,
// leading-zero suppression, per-digit blanking and a dark guard interval per slot.
module seven_segment_scanner #(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int GUARD          = 64,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int LZ_SUPPRESS    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seven_segment_scanner_if.slave  disp
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic SEG_OFF = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_OFF  = (AN_ACTIVE_LOW != 0);

  logic [DIV_W-1:0]    div_cnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] value_sh;
  logic [DIGITS-1:0]   dp_sh;
  logic [DIGITS-1:0]   blank_sh;
  logic                load_pending;

  logic                slot_end;
  logic                wrap;
  logic                load;
  logic                guard;
  logic                lz_run;
  logic [DIGITS-1:0]   lz_dark;
  logic [DIGITS-1:0]   an_sel;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_dark;
  logic                dark;
  logic [DIGITS-1:0]   an_next;
  logic [6:0]          seg_next;
  logic                dp_next;

  logic [DIGITS-1:0]   an_p1;
  logic [6:0]          seg_p1;
  logic                dp_p1;
  logic                frame_tick_p1;

  // Active-high pattern, bit0 = segment a.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

  assign slot_end = (div_cnt == DIV_LAST);
  assign wrap     = slot_end && (idx == IDX_LAST);
  assign load     = wrap || load_pending;

  if (GUARD == 0) begin : g_no_guard
    assign guard = 1'b0;
  end else begin : g_guard
    localparam logic [DIV_W-1:0] GUARD_C = DIV_W'(GUARD);
    assign guard = (div_cnt < GUARD_C);
  end

  // A digit is suppressed only while every more significant digit is suppressed too.
  always_comb begin
    lz_dark = '0;
    lz_run  = (LZ_SUPPRESS != 0);
    for (int i = DIGITS - 1; i > 0; i--) begin
      lz_run     = lz_run && (value_sh[4*i +: 4] == 4'h0) && !dp_sh[i];
      lz_dark[i] = lz_run;
    end
  end

  always_comb begin
    an_sel   = '0;
    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    cur_dark = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        an_sel[i] = 1'b1;
        cur_nib   = value_sh[4*i +: 4];
        cur_dp    = dp_sh[i];
        cur_dark  = blank_sh[i] | lz_dark[i];
      end
    end
  end

  always_comb begin
    dark = cur_dark | guard | !disp.enable;
    if (dark) begin
      an_next  = {DIGITS{AN_OFF}};
      seg_next = {7{SEG_OFF}};
      dp_next  = SEG_OFF;
    end else begin
      an_next  = an_sel ^ {DIGITS{AN_OFF}};
      seg_next = hex_decode(cur_nib) ^ {7{SEG_OFF}};
      dp_next  = cur_dp ^ SEG_OFF;
    end
  end

  // Stage p0: scan counters and frame-synchronous shadow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt      <= '0;
      idx          <= '0;
      value_sh     <= '0;
      dp_sh        <= '0;
      blank_sh     <= '0;
      load_pending <= 1'b1;
    end else begin
      div_cnt      <= slot_end ? '0 : div_cnt + 1'b1;
      if (slot_end) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      if (load) begin
        value_sh <= disp.value;
        dp_sh    <= disp.dp_in;
        blank_sh <= disp.blank;
      end
      load_pending <= 1'b0;
    end
  end

  // Stage p1: registered pin drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_p1         <= {DIGITS{AN_OFF}};
      seg_p1        <= {7{SEG_OFF}};
      dp_p1         <= SEG_OFF;
      frame_tick_p1 <= 1'b0;
    end else begin
      an_p1         <= an_next;
      seg_p1        <= seg_next;
      dp_p1         <= dp_next;
      frame_tick_p1 <= wrap;
    end
  end

  assign disp.an         = an_p1;
  assign disp.seg        = seg_p1;
  assign disp.dp         = dp_p1;
  assign disp.frame_tick = frame_tick_p1;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench: two scanners (active-low and active-high pins) driven in lockstep.
module tb_seven_segment_scanner;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
  } exp_t;

  localparam exp_t OFF = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, ft: 1'b0};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seven_segment_scanner_if #(.DIGITS(4)) lo_if ();
  seven_segment_scanner_if #(.DIGITS(4)) hi_if ();

  seven_segment_scanner #(
    .DIGITS(4), .REFRESH_DIV(4), .GUARD(1),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .LZ_SUPPRESS(1)
  ) u_lo (
    .clk(clk), .rst_n(rst_n), .disp(lo_if.slave)
  );

  seven_segment_scanner #(
    .DIGITS(4), .REFRESH_DIV(4), .GUARD(1),
    .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0), .LZ_SUPPRESS(1)
  ) u_hi (
    .clk(clk), .rst_n(rst_n), .disp(hi_if.slave)
  );

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic set_inputs(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    lo_if.value = v;  hi_if.value = v;
    lo_if.dp_in = d;  hi_if.dp_in = d;
    lo_if.blank = b;  hi_if.blank = b;
  endtask

  task automatic set_enable(input logic en);
    lo_if.enable = en;
    hi_if.enable = en;
  endtask

  task automatic push(input exp_t e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // segs = {s3,s2,s1,s0} in active-low form; dps = lit mask; dark = digits expected dark.
  task automatic push_frame(input logic [27:0] segs, input logic [3:0] dps,
                            input logic [3:0] dark, input string tag, input int n);
    logic [3:0] one;
    exp_t e;
    one = 4'b0001;
    for (int k = 0; k < n; k++) begin
      int slot;
      slot = k / 4;
      e = OFF;
      if ((k % 4) != 0 && !dark[slot]) begin
        e.an  = ~(one << slot);
        e.seg = segs[slot*7 +: 7];
        e.dp  = ~dps[slot];
      end
      e.ft = (k == 15);
      push(e, $sformatf("%s[%0d]", tag, k));
    end
  endtask

  task automatic wait_ft();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (lo_if.frame_tick !== 1'b1 && n < 40);
    checks++;
    if (lo_if.frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL frame_tick_wait: frame_tick=%b after %0d cycles, required 1 within 40", lo_if.frame_tick, n);
    end
  endtask

  task automatic do_frame(input logic en, input logic [27:0] segs, input logic [3:0] dps,
                          input logic [3:0] dark, input string tag,
                          input logic [15:0] nv, input logic [3:0] nd, input logic [3:0] nb);
    wait_ft();
    set_enable(en);
    push_frame(segs, dps, dark, tag, 16);
    repeat (7) @(negedge clk);
    set_inputs(nv, nd, nb);
  endtask

  task automatic reset_and_frame(input int hold, input logic [27:0] segs, input logic [3:0] dps,
                                 input logic [3:0] dark, input string tag,
                                 input logic [15:0] nv, input logic [3:0] nd, input logic [3:0] nb);
    for (int i = 0; i <= hold; i++) push(OFF, $sformatf("reset[%0d]", i));
    rst_n = 1'b0;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_frame(segs, dps, dark, tag, 16);
    @(posedge clk);
    repeat (7) @(negedge clk);
    set_inputs(nv, nd, nb);
  endtask

  // Monitor: outputs are sampled 1 time unit after every clock edge or reset assertion.
  initial begin
    exp_t e, h, a;
    string t;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a = '{an: lo_if.an, seg: lo_if.seg, dp: lo_if.dp, ft: lo_if.frame_tick};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s lo: got an=%b seg=%h dp=%b ft=%b, want an=%b seg=%h dp=%b ft=%b",
                   t, a.an, a.seg, a.dp, a.ft, e.an, e.seg, e.dp, e.ft);
        end
        h = '{an: ~e.an, seg: ~e.seg, dp: ~e.dp, ft: e.ft};
        a = '{an: hi_if.an, seg: hi_if.seg, dp: hi_if.dp, ft: hi_if.frame_tick};
        checks++;
        if (a !== h) begin
          errors++;
          $display("FAIL %s hi: got an=%b seg=%h dp=%b ft=%b, want an=%b seg=%h dp=%b ft=%b",
                   t, a.an, a.seg, a.dp, a.ft, h.an, h.seg, h.dp, h.ft);
        end
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b1;
    set_inputs(16'hFFFF, 4'b0000, 4'b0000);
    set_enable(1'b1);
    #2;
    reset_and_frame(3, {7'h0E, 7'h0E, 7'h0E, 7'h0E}, 4'b0000, 4'b0000, "ffff",
                    16'h12AF, 4'b0000, 4'b0000);
    do_frame(1'b1, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b0000, 4'b0000, "12af",
             16'h0050, 4'b0000, 4'b0000);
    do_frame(1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b0000, 4'b1100, "lz_0050",
             16'h0050, 4'b0100, 4'b0000);
    do_frame(1'b1, {7'h7F, 7'h40, 7'h12, 7'h40}, 4'b0100, 4'b1000, "lz_dp",
             16'h1111, 4'b0000, 4'b0000);
    do_frame(1'b1, {7'h79, 7'h79, 7'h79, 7'h79}, 4'b0000, 4'b0000, "tear_1111",
             16'h2222, 4'b0000, 4'b0000);
    do_frame(1'b1, {7'h24, 7'h24, 7'h24, 7'h24}, 4'b0000, 4'b0000, "tear_2222",
             16'h2222, 4'b0000, 4'b0000);
    do_frame(1'b0, {7'h24, 7'h24, 7'h24, 7'h24}, 4'b0000, 4'b1111, "disabled",
             16'h2222, 4'b0000, 4'b0001);
    do_frame(1'b1, {7'h24, 7'h24, 7'h24, 7'h24}, 4'b0000, 4'b0001, "blank0",
             16'h0000, 4'b0000, 4'b0000);
    do_frame(1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0000, 4'b1110, "all_zero",
             16'hC0D7, 4'b0000, 4'b0000);
    do_frame(1'b1, {7'h46, 7'h40, 7'h21, 7'h78}, 4'b0000, 4'b0000, "c0d7",
             16'h3456, 4'b0000, 4'b0000);

    // Reset asserted between clock edges while slot 2 is lit.
    wait_ft();
    push_frame({7'h30, 7'h19, 7'h12, 7'h02}, 4'b0000, 4'b0000, "pre_rst", 10);
    repeat (10) @(posedge clk);
    #3;
    reset_and_frame(2, {7'h30, 7'h19, 7'h12, 7'h02}, 4'b0000, 4'b0000, "post_rst",
                    16'h3456, 4'b0000, 4'b0000);

    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Parametrised, time-multiplexed driver for a bank of common-anode or common-cathode seven-segment digits. It replaces per-digit combinational decoding with a single shared hex decoder and a refresh scanner. It also adds frame-synchronous input latching, leading-zero suppression, per-digit blanking, decimal points and an anti-ghosting guard interval. It sits between the game score/debug logic and the board's segment/anode pins.

## Interface
Parameters:
- DIGITS, 4, number of digits scanned (1..8)
- REFRESH_DIV, 50000, clock cycles per digit slot (>= GUARD+1)
- GUARD, 64, cycles at the start of each slot with all anodes inactive (0 disables)
- SEG_ACTIVE_LOW, 1, 1: segment/dp outputs low = lit
- AN_ACTIVE_LOW, 1, 1: anode outputs low = digit enabled
- LZ_SUPPRESS, 1, 1: enable leading-zero suppression

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- value  in  4*DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i, digit 0 = least significant
- dp_in  in  DIGITS  decimal point request per digit
- blank  in  DIGITS  force digit dark
- enable  in  1  0: all anodes inactive, scanning continues
- seg  out  7  segments {g,f,e,d,c,b,a}, bit0 = a
- dp  out  1  decimal point
- an  out  DIGITS  one-hot digit enable
- frame_tick  out  1  one-cycle pulse when the scan wraps to digit 0

## Operation
- Prescaler `div_cnt` counts 0..REFRESH_DIV-1 and wraps. At the terminal count, digit index `idx` advances, wrapping from DIGITS-1 to 0.
- Shadow registers hold value/dp_in/blank and load in two cases:
  - in the cycle `idx` wraps to 0, with frame_tick asserted in the following cycle;
  - once, on the first clock after rst_n deasserts. A load_pending flag is set by reset for this.
- The displayed data never changes mid-frame (no tearing).
- Decode, active-high pattern:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - A=77, b=7C, C=39, d=5E, E=79, F=71
  - SEG_ACTIVE_LOW inverts seg and dp.
- Leading-zero suppression (LZ_SUPPRESS=1): digit i>0 is dark if its shadow nibble is 0, shadow dp for that digit is 0, and every more significant digit is also suppressed. Digit 0 is never suppressed.
- A dark digit (blank, suppressed, guard, enable=0) has:
  - an inactive;
  - seg and dp driven to the unlit level.
- Selected digit: an has exactly one active bit at position idx. Polarity follows AN_ACTIVE_LOW.
- Guard: while div_cnt < GUARD, all anodes are inactive and seg is unlit.

## Timing
- Reset values:
  - div_cnt=0, idx=0, shadows=0, load_pending=1;
  - an = all inactive, seg = unlit, dp = unlit, frame_tick=0.
- All outputs are registered. an, seg and dp reflect idx and div_cnt of the previous cycle (1-cycle latency).
- The slot for digit k lasts exactly REFRESH_DIV cycles. The full frame lasts DIGITS*REFRESH_DIV cycles.
- The frame_tick pulse occurs once per frame, 1 cycle after the idx wrap edge, and is never wider than 1 cycle.
- The shadow load and the new idx=0 take effect in the same cycle. Digit 0 of the new frame therefore already shows the new data.
- Input changes at any other time are ignored until the next wrap.
- enable is applied combinationally to the output register input, so it takes effect on the next clock. It does not reset the counters.
- rst_n asserted mid-slot forces all outputs to reset values immediately (asynchronous). Scanning restarts at idx=0, div_cnt=0 on the first clock after release.
- DIGITS=1: idx stays 0, and frame_tick pulses every REFRESH_DIV cycles.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with value=FFFF, defaults. Required: an=1111, seg=7F, dp=1, frame_tick=0. After release, digit 0 shows F (seg=0E) once its guard elapses.
- Scan order: DIGITS=4, REFRESH_DIV=4, GUARD=1, value=12AF. Required per 4-cycle slot:
  - 1 dark cycle, then 3 cycles of the slot's pattern;
  - slot sequence: an=1110/seg=0E, an=1101/seg=08, an=1011/seg=24, an=0111/seg=79;
  - frame_tick every 16 cycles.
- Leading zeros: value=0050.
  - Required: digits 3 and 2 dark, digit 1 seg=12, digit 0 seg=40.
  - With dp_in=0100, digit 2 shows 0 with dp lit and digit 3 stays dark.
- Tearing: change value from 1111 to 2222 mid-frame. Required: all digits keep showing 1 until the frame_tick frame boundary, then all show 2.
- Enable/blank: enable=0 for one full frame gives an=1111 throughout while frame_tick continues. blank=0001 keeps digit 0 dark.
- Reset mid-operation: assert rst_n in slot 2. Required: outputs reach reset values within the same cycle, and restart at idx=0. Then repeat with SEG_ACTIVE_LOW=0 and AN_ACTIVE_LOW=0 and check inverted polarities.
